// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-VC input FIFOs with XY routing, wormhole locking and output steering
package ravenoc_pkg;
  localparam int NumVirtChn = 2;
  localparam int VcWidth = 1;
  localparam int XWidth = 2;
  localparam int YWidth = 2;
  localparam int PktWidth = 8;
  typedef enum logic {ZeroLowPrior, ZeroHighPrior} priority_t;
  localparam priority_t HighPriority = ZeroLowPrior;
  typedef enum logic [1:0] {HEAD_FLIT, BODY_FLIT, TAIL_FLIT} flit_type_t;
  typedef struct packed {
    flit_type_t type_f;
    logic [XWidth-1:0] x_dest;
    logic [YWidth-1:0] y_dest;
    logic [PktWidth-1:0] pkt_size;
  } s_flit_data_t;
  typedef struct packed {
    logic valid;
    logic [VcWidth-1:0] vc_id;
    s_flit_data_t fdata;
  } s_flit_req_t;
  typedef struct packed {
    logic ready;
  } s_flit_resp_t;
endpackage

module vc_input_buffer
  import ravenoc_pkg::*;
#(
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int IN_DIR = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  s_flit_req_t       fin_req_i,
  output s_flit_resp_t      fin_resp_o,
  output s_flit_req_t [3:0] fout_req_o,
  input  s_flit_resp_t [3:0] fout_resp_i,
  output logic              err_o
);
  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [2:0] DirLocal = 3'd0;
  localparam logic [2:0] DirNorth = 3'd1;
  localparam logic [2:0] DirSouth = 3'd2;
  localparam logic [2:0] DirWest = 3'd3;
  localparam logic [2:0] DirEast = 3'd4;
  localparam logic [2:0] InDir = 3'(IN_DIR);
  localparam logic [XWidth-1:0] RouterX = XWidth'(ROUTER_X);
  localparam logic [YWidth-1:0] RouterY = YWidth'(ROUTER_Y);
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);
  typedef enum logic {IDLE, BUSY} vc_state_t;
  s_flit_data_t mem [NumVirtChn][FIFO_DEPTH];
  logic [NumVirtChn-1:0][PtrW-1:0] wptr, rptr;
  logic [NumVirtChn-1:0][CntW-1:0] cnt;
  logic [NumVirtChn-1:0] push, pop, non_empty;
  vc_state_t state [NumVirtChn];
  vc_state_t state_nx [NumVirtChn];
  logic [2:0] dir_q [NumVirtChn];
  logic [2:0] dir_nx [NumVirtChn];
  logic hold_vld;
  logic [VcWidth-1:0] hold_vc, pick_vc, sel_vc;
  s_flit_data_t head;
  logic [2:0] xy_dir, dir;
  logic [1:0] idx;
  logic any_vld, is_idle, illegal, drop, present, accept;
  // Upstream ready reflects only the addressed FIFO's pre-pop occupancy
  always_comb begin
    fin_resp_o.ready = cnt[fin_req_i.vc_id] != Full;
    for (int v = 0; v < NumVirtChn; v++) begin
      push[v] = fin_req_i.valid && fin_resp_o.ready && fin_req_i.vc_id == VcWidth'(v);
      non_empty[v] = cnt[v] != '0;
    end
  end
  // Priority pick among non-empty VCs; the last match in scan order wins
  always_comb begin
    pick_vc = '0;
    for (int v = 0; v < NumVirtChn; v++) begin
      if (HighPriority == ZeroLowPrior && non_empty[v]) pick_vc = VcWidth'(v);
      if (HighPriority != ZeroLowPrior && non_empty[NumVirtChn-1-v]) pick_vc = VcWidth'(NumVirtChn-1-v);
    end
  end
  // Route the selected head: held choice wins over a fresh pick until accepted
  always_comb begin
    sel_vc = hold_vld ? hold_vc : pick_vc;
    any_vld = non_empty[sel_vc];
    head = mem[sel_vc][rptr[sel_vc]];
    xy_dir = head.x_dest > RouterX ? DirEast :
             head.x_dest < RouterX ? DirWest :
             head.y_dest > RouterY ? DirSouth :
             head.y_dest < RouterY ? DirNorth : DirLocal;
    is_idle = state[sel_vc] == IDLE;
    dir = is_idle ? xy_dir : dir_q[sel_vc];
    idx = dir < InDir ? dir[1:0] : 2'(dir - 3'd1);
    illegal = any_vld && is_idle && head.type_f == HEAD_FLIT && dir == InDir;
    drop = any_vld && is_idle && (head.type_f != HEAD_FLIT || dir == InDir);
    present = any_vld && !drop;
    accept = present && fout_resp_i[idx].ready;
    for (int v = 0; v < NumVirtChn; v++) pop[v] = (drop || accept) && sel_vc == VcWidth'(v);
  end
  // Drive exactly one output module with the selected flit
  always_comb begin
    fout_req_o = '0;
    if (present) fout_req_o[idx] = '{valid: 1'b1, vc_id: sel_vc, fdata: head};
  end
  // Per-VC wormhole state register
  always_ff @(posedge clk) begin
    for (int v = 0; v < NumVirtChn; v++) begin
      state[v] <= arst ? IDLE : state_nx[v];
      dir_q[v] <= arst ? 3'd0 : dir_nx[v];
    end
  end
  // Accepted multi-flit heads lock the direction; tails release it
  always_comb begin
    for (int v = 0; v < NumVirtChn; v++) begin
      state_nx[v] = state[v];
      dir_nx[v] = dir_q[v];
      if (accept && sel_vc == VcWidth'(v)) begin
        if (state[v] == IDLE && head.type_f == HEAD_FLIT && head.pkt_size != '0) begin
          state_nx[v] = BUSY;
          dir_nx[v] = dir;
        end
        if (state[v] == BUSY && head.type_f == TAIL_FLIT) state_nx[v] = IDLE;
      end
    end
  end
  // FIFO storage; contents need no reset since counts gate visibility
  always_ff @(posedge clk) begin
    for (int v = 0; v < NumVirtChn; v++)
      if (push[v]) mem[v][wptr[v]] <= fin_req_i.fdata;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (arst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      for (int v = 0; v < NumVirtChn; v++) begin
        if (push[v]) wptr[v] <= wptr[v] + PtrW'(1);
        if (pop[v]) rptr[v] <= rptr[v] + PtrW'(1);
        cnt[v] <= cnt[v] + CntW'(push[v]) - CntW'(pop[v]);
      end
    end
  end
  // Selection hold while a presented flit is stalled, and the drop error pulse
  always_ff @(posedge clk) begin
    if (arst) begin
      hold_vld <= 1'b0;
      hold_vc <= '0;
      err_o <= 1'b0;
    end else begin
      hold_vld <= present && !accept;
      hold_vc <= sel_vc;
      err_o <= illegal;
    end
  end
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: directed table and corner-case sequences for vc_input_buffer
module tb_vc_input_buffer;
  import ravenoc_pkg::*;
  typedef s_flit_req_t [3:0] fout_t;
  typedef struct {
    logic [VcWidth-1:0] vc;
    logic [1:0] x;
    logic [1:0] y;
    int idx;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic arst = 1'b1;
  s_flit_req_t fin_req;
  s_flit_resp_t fin_resp;
  fout_t fout_req;
  s_flit_resp_t [3:0] fout_resp;
  logic err;
  int total = 0;
  int passed = 0;
  vec_t tbl [8];
  s_flit_req_t f, h, b, t, s;
  s_flit_req_t p [5];
  fout_t zero_out;

  always #5 clk = ~clk;

  vc_input_buffer #(.ROUTER_X(1), .ROUTER_Y(1), .IN_DIR(3), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .arst(arst),
    .fin_req_i(fin_req),
    .fin_resp_o(fin_resp),
    .fout_req_o(fout_req),
    .fout_resp_i(fout_resp),
    .err_o(err)
  );

  function automatic s_flit_req_t mk(logic [VcWidth-1:0] vc, flit_type_t ty, logic [1:0] x, logic [1:0] y, logic [7:0] sz);
    s_flit_req_t r;
    r.valid = 1'b1;
    r.vc_id = vc;
    r.fdata.type_f = ty;
    r.fdata.x_dest = x;
    r.fdata.y_dest = y;
    r.fdata.pkt_size = sz;
    return r;
  endfunction

  function automatic fout_t exp_out(int idx, s_flit_req_t fl);
    fout_t o;
    o = '0;
    if (idx >= 0) o[idx] = fl;
    return o;
  endfunction

  task automatic chk_bit(string name, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_out(string name, fout_t act, fout_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    zero_out = '0;
    tbl[0] = '{1'b0, 2'd2, 2'd1, 3, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 2'd0, 1, 1'b0};
    tbl[2] = '{1'b0, 2'd1, 2'd2, 2, 1'b0};
    tbl[3] = '{1'b1, 2'd1, 2'd1, 0, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 2'd1, -1, 1'b1};
    tbl[5] = '{1'b1, 2'd3, 2'd3, 3, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 2'd3, -1, 1'b1};
    tbl[7] = '{1'b1, 2'd1, 2'd3, 2, 1'b0};
    fin_req = '0;
    fout_resp = '1;
    nxt;
    nxt;
    chk_out("reset_fout", fout_req, zero_out);
    chk_bit("reset_ready", fin_resp.ready, 1'b1);
    chk_bit("reset_err", err, 1'b0);
    arst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f = mk(tbl[i].vc, HEAD_FLIT, tbl[i].x, tbl[i].y, 8'd0);
      fin_req = f;
      #1;
      chk_bit($sformatf("vec%0d_ready", i), fin_resp.ready, 1'b1);
      nxt;
      fin_req = '0;
      chk_out($sformatf("vec%0d_out", i), fout_req, exp_out(tbl[i].idx, f));
      chk_bit($sformatf("vec%0d_err_pre", i), err, 1'b0);
      nxt;
      chk_out($sformatf("vec%0d_drained", i), fout_req, zero_out);
      chk_bit($sformatf("vec%0d_err", i), err, tbl[i].err);
      nxt;
      chk_bit($sformatf("vec%0d_err_post", i), err, 1'b0);
    end
    h = mk(1'b0, HEAD_FLIT, 2'd1, 2'd0, 8'd2);
    b = mk(1'b0, BODY_FLIT, 2'd2, 2'd1, 8'd0);
    t = mk(1'b0, TAIL_FLIT, 2'd2, 2'd1, 8'd0);
    fin_req = h;
    nxt;
    chk_out("lock_head", fout_req, exp_out(1, h));
    fin_req = b;
    nxt;
    chk_out("lock_body", fout_req, exp_out(1, b));
    fin_req = t;
    nxt;
    chk_out("lock_tail", fout_req, exp_out(1, t));
    fin_req = '0;
    nxt;
    chk_out("lock_done", fout_req, zero_out);
    s = mk(1'b0, HEAD_FLIT, 2'd2, 2'd1, 8'd0);
    fin_req = s;
    nxt;
    fin_req = '0;
    chk_out("lock_released", fout_req, exp_out(3, s));
    nxt;
    fout_resp = '0;
    p[0] = mk(1'b1, HEAD_FLIT, 2'd2, 2'd1, 8'd4);
    p[1] = mk(1'b1, BODY_FLIT, 2'd0, 2'd0, 8'd0);
    p[2] = mk(1'b1, BODY_FLIT, 2'd3, 2'd2, 8'd0);
    p[3] = mk(1'b1, BODY_FLIT, 2'd1, 2'd3, 8'd0);
    p[4] = mk(1'b1, TAIL_FLIT, 2'd2, 2'd2, 8'd0);
    for (int k = 0; k < 5; k++) begin
      fin_req = p[k];
      #1;
      chk_bit($sformatf("bp_ready%0d", k), fin_resp.ready, k < 4);
      nxt;
    end
    chk_bit("bp_held_ready", fin_resp.ready, 1'b0);
    chk_out("bp_stalled_head", fout_req, exp_out(3, p[0]));
    fout_resp = '1;
    #1;
    chk_bit("bp_no_same_cycle_free", fin_resp.ready, 1'b0);
    nxt;
    chk_bit("bp_ready_back", fin_resp.ready, 1'b1);
    chk_out("bp_drain1", fout_req, exp_out(3, p[1]));
    nxt;
    fin_req = '0;
    chk_out("bp_drain2", fout_req, exp_out(3, p[2]));
    nxt;
    chk_out("bp_drain3", fout_req, exp_out(3, p[3]));
    nxt;
    chk_out("bp_drain4", fout_req, exp_out(3, p[4]));
    nxt;
    chk_out("bp_empty", fout_req, zero_out);
    h = mk(1'b0, HEAD_FLIT, 2'd0, 2'd1, 8'd1);
    t = mk(1'b0, TAIL_FLIT, 2'd0, 2'd1, 8'd0);
    fin_req = h;
    nxt;
    fin_req = t;
    chk_out("ill_head_out", fout_req, zero_out);
    chk_bit("ill_err_pre", err, 1'b0);
    nxt;
    fin_req = '0;
    chk_out("ill_tail_out", fout_req, zero_out);
    chk_bit("ill_err", err, 1'b1);
    nxt;
    chk_out("ill_after_out", fout_req, zero_out);
    chk_bit("ill_err_once", err, 1'b0);
    s = mk(1'b0, HEAD_FLIT, 2'd1, 2'd2, 8'd0);
    fin_req = s;
    nxt;
    fin_req = '0;
    chk_out("ill_recover", fout_req, exp_out(2, s));
    chk_bit("ill_err_quiet", err, 1'b0);
    nxt;
    fout_resp = '0;
    h = mk(1'b0, HEAD_FLIT, 2'd2, 2'd1, 8'd0);
    b = mk(1'b1, HEAD_FLIT, 2'd1, 2'd0, 8'd0);
    fin_req = h;
    nxt;
    chk_out("prio_first", fout_req, exp_out(3, h));
    fin_req = b;
    nxt;
    fin_req = '0;
    chk_out("prio_hold", fout_req, exp_out(3, h));
    fout_resp = 4'b0010;
    nxt;
    chk_out("prio_ignore_other_ready", fout_req, exp_out(3, h));
    fout_resp = '1;
    nxt;
    chk_out("prio_second", fout_req, exp_out(1, b));
    nxt;
    chk_out("prio_empty", fout_req, zero_out);
    h = mk(1'b0, HEAD_FLIT, 2'd1, 2'd0, 8'd2);
    b = mk(1'b0, BODY_FLIT, 2'd2, 2'd1, 8'd0);
    fin_req = h;
    nxt;
    chk_out("rst_head", fout_req, exp_out(1, h));
    fin_req = b;
    nxt;
    fin_req = '0;
    chk_out("rst_body", fout_req, exp_out(1, b));
    fout_resp = '0;
    arst = 1'b1;
    nxt;
    chk_out("rst_fout", fout_req, zero_out);
    chk_bit("rst_ready", fin_resp.ready, 1'b1);
    chk_bit("rst_err", err, 1'b0);
    arst = 1'b0;
    s = mk(1'b0, HEAD_FLIT, 2'd1, 2'd2, 8'd0);
    fin_req = s;
    nxt;
    fin_req = '0;
    chk_out("rst_fresh", fout_req, exp_out(2, s));
    fout_resp = '1;
    nxt;
    chk_out("rst_final_empty", fout_req, zero_out);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 The block SHALL have parameter ROUTER_X, default 0, meaning this router's X coordinate.
REQ-002 The block SHALL have parameter ROUTER_Y, default 0, meaning this router's Y coordinate.
REQ-003 The block SHALL have parameter IN_DIR, default 3, meaning own input direction (0 LOCAL, 1 NORTH, 2 SOUTH, 3 WEST, 4 EAST).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning per-VC buffer depth in flits; it is a power of two and at least 2.
REQ-005 The block SHALL take VC count, VC width and priority order from ravenoc_pkg (NumVirtChn, VcWidth, HighPriority).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port arst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port fin_req_i, input, s_flit_req_t: incoming flit with valid, vc_id and fdata (type_f, x_dest, y_dest, pkt_size).
REQ-009 The block SHALL have port fin_resp_o, output, s_flit_resp_t: ready to the upstream link.
REQ-010 The block SHALL have port fout_req_o, output, s_flit_req_t [3:0]: requests to the four output modules.
REQ-011 The block SHALL have port fout_resp_i, input, s_flit_resp_t [3:0]: ready from the four output modules.
REQ-012 The block SHALL have port err_o, output, 1 bit: one-cycle pulse when an illegal-route flit is dropped.

Function
REQ-013 The block SHALL hold one FIFO_DEPTH-deep FIFO per VC, with wrap-around read/write pointers and a count of width $clog2(FIFO_DEPTH)+1.
REQ-014 fin_resp_o.ready SHALL be asserted combinationally iff the FIFO selected by fin_req_i.vc_id is not full; a pop in the same cycle SHALL NOT free space for a push.
REQ-015 The block SHALL push on fin_req_i.valid && fin_resp_o.ready; a flit pushed at edge N SHALL be visible on fout_req_o no earlier than cycle N+1.
REQ-016 Per VC, the block SHALL keep state IDLE or BUSY with a 3-bit latched direction.
REQ-017 In IDLE, the direction SHALL be computed by XY routing on the FIFO head: x_dest>ROUTER_X gives EAST, x_dest<ROUTER_X gives WEST, otherwise y_dest>ROUTER_Y gives SOUTH, y_dest<ROUTER_Y gives NORTH, otherwise LOCAL.
REQ-018 In BUSY, the latched direction SHALL be used.
REQ-019 A popped HEAD_FLIT with pkt_size!=0 SHALL take the VC from IDLE to BUSY, latching the direction.
REQ-020 A popped TAIL_FLIT SHALL take the VC from BUSY to IDLE.
REQ-021 A single-flit packet (HEAD_FLIT, pkt_size==0) SHALL keep the VC in IDLE.
REQ-022 The output index SHALL be dir when dir<IN_DIR, and dir-1 when dir>IN_DIR.
REQ-023 dir==IN_DIR SHALL be an illegal route: the head flit is popped without any fout_req_o valid, err_o pulses for one cycle, and the VC stays IDLE so following body/tail flits are also dropped until the next head; err_o SHALL pulse once per dropped packet.
REQ-024 VC selection: among non-empty VCs, HighPriority==ZeroLowPrior SHALL favour the highest VC index and any other setting the lowest.
REQ-025 Once a flit is presented and not yet accepted, the selected VC, flit and index SHALL be held stable even if a higher-priority VC becomes non-empty.
REQ-026 Exactly one fout_req_o[idx] SHALL carry {valid=1, vc_id=selected VC, fdata=FIFO head}; the other three SHALL be all-zero.
REQ-027 The block SHALL pop when fout_resp_i[idx].ready is high with valid; ready on non-selected outputs SHALL be ignored.
REQ-028 Throughput SHALL be one flit per cycle when the downstream is always ready.

Reset
REQ-029 On clk edge with arst=1, the block SHALL empty all FIFOs, set all VCs to IDLE, clear directions and the selection hold, and set err_o=0.
REQ-030 During and after reset, fout_req_o SHALL be all-zero and fin_resp_o.ready=1.
REQ-031 Reset mid-packet SHALL discard all buffered flits and route state, with no partial flit emitted afterwards.

Verification
REQ-032 A bench SHALL cover the XY single flit: ROUTER_X=1, ROUTER_Y=1, IN_DIR=WEST, head x_dest=2 y_dest=1 pkt_size=0 on VC0 -> fout_req_o[3] valid next cycle, vc_id=0, VC stays IDLE.
REQ-033 A bench SHALL cover a multi-flit lock: head (x=1,y=0,size=2), body, tail -> all three on fout_req_o[1] (NORTH), VC BUSY after head, IDLE after tail, back-to-back with ready=1.
REQ-034 A bench SHALL cover full backpressure: FIFO_DEPTH=4, fout ready=0, push 5 flits VC1 -> ready drops after the 4th; 5th held; after releasing ready the flits drain in order.
REQ-035 A bench SHALL cover an illegal route: IN_DIR=WEST, head x_dest=0 size=1 then tail -> no fout valid, err_o high exactly one cycle, both flits consumed.
REQ-036 A bench SHALL cover priority hold: VC0 flit stalled (ready=0), then VC1 flit arrives -> VC0 stays presented until accepted, then VC1 appears.
REQ-037 A bench SHALL cover reset mid-packet: assert arst after head of a 3-flit packet -> next cycle outputs zero, ready=1, and a fresh single-flit packet routes correctly.
